// File: rtl/rect_fill.sv
// Rectangle fill engine: clips a command to the framebuffer and
// streams one pixel write per unpaused cycle in row-major order.
module rect_fill #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x,
  input  logic [7:0] cmd_y,
  input  logic [7:0] cmd_w,
  input  logic [7:0] cmd_h,
  input  logic [7:0] cmd_color,
  input  logic       pause,
  output logic [7:0] x_data,
  output logic [7:0] y_data,
  output logic [7:0] color,
  output logic       write,
  output logic       busy,
  output logic       done
);

  localparam logic [8:0] W9 = 9'(WIDTH);
  localparam logic [8:0] H9 = 9'(HEIGHT);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0] x0;
  logic [7:0] xe;
  logic [7:0] ye;
  logic [7:0] cx;
  logic [7:0] cy;
  logic [7:0] col;

  logic [8:0] x_sum;
  logic [8:0] y_sum;
  logic [8:0] x_clip;
  logic [8:0] y_clip;
  logic [7:0] xe_nxt;
  logic [7:0] ye_nxt;
  logic       empty;
  logic       accept;
  logic       step;
  logic       row_end;
  logic       last;

  // 9-bit sums so x+w past 255 still clips correctly
  always_comb begin
    x_sum  = {1'b0, cmd_x} + {1'b0, cmd_w};
    y_sum  = {1'b0, cmd_y} + {1'b0, cmd_h};
    x_clip = (x_sum > W9) ? W9 : x_sum;
    y_clip = (y_sum > H9) ? H9 : y_sum;
    xe_nxt = 8'(x_clip - 9'd1);
    ye_nxt = 8'(y_clip - 9'd1);
    empty  = (cmd_w == 8'd0)
          || (cmd_h == 8'd0)
          || ({1'b0, cmd_x} >= W9)
          || ({1'b0, cmd_y} >= H9);
  end

  assign accept  = cmd_valid && (state == IDLE);
  assign step    = (state == DRAW) && !pause;
  assign row_end = (cx == xe);
  assign last    = row_end && (cy == ye);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    write     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = empty ? DONE : DRAW;
        end
      end
      DRAW: begin
        busy  = 1'b1;
        write = !pause;
        if (step && last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0  <= 8'd0;
      xe  <= 8'd0;
      ye  <= 8'd0;
      cx  <= 8'd0;
      cy  <= 8'd0;
      col <= 8'd0;
    end else if (accept) begin
      x0  <= cmd_x;
      xe  <= xe_nxt;
      ye  <= ye_nxt;
      cx  <= cmd_x;
      cy  <= cmd_y;
      col <= cmd_color;
    end else if (step) begin
      if (row_end) begin
        cx <= x0;
        if (!last) begin
          cy <= cy + 8'd1;
        end
      end else begin
        cx <= cx + 8'd1;
      end
    end
  end

  assign x_data = cx;
  assign y_data = cy;
  assign color  = col;

endmodule

// File: tb/tb_rect_fill.sv
// Randomised and directed bench for rect_fill against a
// pixel-index reference model.
module tb_rect_fill;

  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x = 8'd0;
  logic [7:0] cmd_y = 8'd0;
  logic [7:0] cmd_w = 8'd0;
  logic [7:0] cmd_h = 8'd0;
  logic [7:0] cmd_color = 8'd0;
  logic       pause = 1'b0;
  logic [7:0] x_data;
  logic [7:0] y_data;
  logic [7:0] color;
  logic       write;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  rect_fill #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x    (cmd_x),
    .cmd_y    (cmd_y),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .pause    (pause),
    .x_data   (x_data),
    .y_data   (y_data),
    .color    (color),
    .write    (write),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1 draw, 2 done; k = pixels already written
  int  ph = 0;
  int  k = 0;
  int  wc = 0;
  int  hc = 0;
  int  mx0 = 0;
  int  my0 = 0;
  int  mc = 0;
  bit  clean = 0;
  bit  started = 0;

  always @(posedge clk) begin
    if (rst) begin
      ph = 0;
      clean = 1;
      started = 1;
    end else begin
      case (ph)
        0: if (cmd_valid) begin
          clean = 0;
          mx0 = cmd_x;
          my0 = cmd_y;
          mc  = cmd_color;
          if (cmd_w == 0 || cmd_h == 0 ||
              cmd_x >= WIDTH || cmd_y >= HEIGHT) begin
            ph = 2;
          end else begin
            wc = ((cmd_x + cmd_w > WIDTH) ? WIDTH
                  : int'(cmd_x) + int'(cmd_w)) - mx0;
            hc = ((cmd_y + cmd_h > HEIGHT) ? HEIGHT
                  : int'(cmd_y) + int'(cmd_h)) - my0;
            k  = 0;
            ph = 1;
          end
        end
        1: if (!pause) begin
          k++;
          if (k == wc * hc) ph = 2;
        end
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready", int'(cmd_ready), int'(ph == 0));
      chk("busy", int'(busy), int'(ph != 0));
      chk("done", int'(done), int'(ph == 2));
      chk("write", int'(write), int'(ph == 1 && !pause));
      if (ph == 1) begin
        chk("x", int'(x_data), mx0 + k % wc);
        chk("y", int'(y_data), my0 + k / wc);
        chk("color", int'(color), mc);
      end
      if (write) begin
        chk("x_range", int'(x_data < WIDTH), 1);
        chk("y_range", int'(y_data < HEIGHT), 1);
      end
      if (clean) begin
        chk("rst_x", int'(x_data), 0);
        chk("rst_y", int'(y_data), 0);
        chk("rst_color", int'(color), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 30000) begin
      step();
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  // returns in cycle 1 after the acceptance edge
  task automatic issue(input int x, input int y, input int w,
                       input int h, input int c);
    wait_ready();
    cmd_x = 8'(x);
    cmd_y = 8'(y);
    cmd_w = 8'(w);
    cmd_h = 8'(h);
    cmd_color = 8'(c);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  int xs1[6] = '{2, 3, 4, 2, 3, 4};
  int ys1[6] = '{3, 3, 3, 4, 4, 4};
  int xs2[4] = '{158, 159, 158, 159};
  int ys2[4] = '{118, 118, 119, 119};

  initial begin
    int nw;
    bit seen;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_write", int'(write), 0);
    chk("reset_x", int'(x_data), 0);
    step();

    issue(2, 3, 3, 2, 'hA5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t1_write", int'(write), 1);
      chk("t1_x", int'(x_data), xs1[i]);
      chk("t1_y", int'(y_data), ys1[i]);
      chk("t1_color", int'(color), 'hA5);
      step();
    end
    @(negedge clk);
    chk("t1_done", int'(done), 1);
    chk("t1_nowrite", int'(write), 0);
    step();
    @(negedge clk);
    chk("t1_ready", int'(cmd_ready), 1);

    issue(158, 118, 10, 10, 'h11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_write", int'(write), 1);
      chk("t2_x", int'(x_data), xs2[i]);
      chk("t2_y", int'(y_data), ys2[i]);
      step();
    end
    @(negedge clk);
    chk("t2_done", int'(done), 1);
    step();

    issue(7, 7, 0, 5, 'h22);
    @(negedge clk);
    chk("t3a_done", int'(done), 1);
    chk("t3a_write", int'(write), 0);
    step();
    @(negedge clk);
    chk("t3a_ready", int'(cmd_ready), 1);
    issue(200, 5, 4, 4, 'h33);
    @(negedge clk);
    chk("t3b_done", int'(done), 1);
    chk("t3b_write", int'(write), 0);
    step();
    @(negedge clk);
    chk("t3b_ready", int'(cmd_ready), 1);

    pause = 1'b1;
    issue(10, 20, 2, 1, 'h5A);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("t4_held_write", int'(write), 0);
      chk("t4_held_x", int'(x_data), 10);
      chk("t4_held_y", int'(y_data), 20);
      step();
    end
    pause = 1'b0;
    @(negedge clk);
    chk("t4_w1", int'(write), 1);
    chk("t4_x1", int'(x_data), 10);
    step();
    @(negedge clk);
    chk("t4_w2", int'(write), 1);
    chk("t4_x2", int'(x_data), 11);
    step();
    @(negedge clk);
    chk("t4_done", int'(done), 1);
    step();

    issue(0, 0, 4, 4, 'h77);
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_c3_write", int'(write), 1);
    step();
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("t5_write", int'(write), 0);
    chk("t5_done", int'(done), 0);
    step();
    rst = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_idle_write", int'(write), 0);
      chk("t5_idle_done", int'(done), 0);
      chk("t5_idle_ready", int'(cmd_ready), 1);
      step();
    end

    wait_ready();
    cmd_x = 8'd50;
    cmd_y = 8'd50;
    cmd_w = 8'd3;
    cmd_h = 8'd3;
    cmd_color = 8'h3C;
    cmd_valid = 1'b1;
    step();
    nw = 0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (write) begin
        nw++;
        chk("t6_color", int'(color), 'h3C);
      end
      if (!done) chk("t6_noaccept", int'(cmd_ready), 0);
      seen = done;
      step();
      cmd_x = 8'($urandom_range(0, 100));
      cmd_y = 8'($urandom_range(0, 100));
      cmd_w = 8'($urandom_range(1, 5));
      cmd_color = 8'($urandom);
    end
    cmd_valid = 1'b0;
    chk("t6_seen_done", int'(seen), 1);
    chk("t6_writes", nw, 9);

    for (int n = 0; n < 8000; n++) begin
      step();
      rst = ($urandom_range(0, 599) == 0);
      cmd_valid = $urandom_range(0, 1);
      pause = ($urandom_range(0, 9) < 3);
      cmd_x = ($urandom_range(0, 3) == 0)
              ? 8'($urandom_range(140, 255))
              : 8'($urandom_range(0, 159));
      cmd_y = ($urandom_range(0, 3) == 0)
              ? 8'($urandom_range(100, 255))
              : 8'($urandom_range(0, 119));
      cmd_w = ($urandom_range(0, 15) == 0)
              ? 8'($urandom) : 8'($urandom_range(0, 8));
      cmd_h = 8'($urandom_range(0, 6));
      cmd_color = 8'($urandom);
    end

    rst = 1'b0;
    cmd_valid = 1'b0;
    pause = 1'b0;
    wait_ready();
    step();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rect_fill.md
RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 The block SHALL have parameter WIDTH, default 160, framebuffer width in pixels.
REQ-002 The block SHALL have parameter HEIGHT, default 120, framebuffer height in pixels.
REQ-003 The block SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port cmd_valid  input  1  command offered.
REQ-006 The block SHALL have port cmd_ready  output  1  block accepts a command this cycle.
REQ-007 The block SHALL have ports cmd_x, cmd_y  input  8 each  top-left corner.
REQ-008 The block SHALL have ports cmd_w, cmd_h  input  8 each  rectangle size in pixels.
REQ-009 The block SHALL have port cmd_color  input  8  fill colour.
REQ-010 The block SHALL have port pause  input  1  framebuffer cannot take a write this cycle.
REQ-011 The block SHALL have ports x_data, y_data  output  8 each  framebuffer write address.
REQ-012 The block SHALL have port color  output  8  framebuffer write data.
REQ-013 The block SHALL have port write  output  1  framebuffer write strobe.
REQ-014 The block SHALL have port busy  output  1  command in progress.
REQ-015 The block SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 The block SHALL implement states IDLE, DRAW, DONE.
REQ-017 cmd_ready SHALL be 1 exactly when the state is IDLE; busy SHALL be 1 in DRAW and DONE.
REQ-018 Acceptance SHALL occur on an edge where cmd_valid=1 and cmd_ready=1; cmd_x, cmd_y, cmd_w, cmd_h, cmd_color are latched then, and later input changes SHALL have no effect.
REQ-019 Clipping SHALL use 9-bit arithmetic: xe=min(cmd_x+cmd_w, WIDTH)-1, ye=min(cmd_y+cmd_h, HEIGHT)-1.
REQ-020 An empty command (cmd_w=0, cmd_h=0, cmd_x>=WIDTH, or cmd_y>=HEIGHT) SHALL go IDLE->DONE, with no write asserted.
REQ-021 Otherwise IDLE->DRAW; the first write SHALL appear in the cycle after acceptance at (cmd_x, cmd_y).
REQ-022 In DRAW, write SHALL equal !pause; x_data/y_data/color SHALL show the current pixel, and the position SHALL advance only on cycles with write=1.
REQ-023 Scan order SHALL be row-major: x increments to xe, then x returns to cmd_x and y increments; the write at (xe, ye) SHALL be the last one.
REQ-024 After the last write, state SHALL go DRAW->DONE; done=1 for exactly the DONE cycle; then DONE->IDLE.
REQ-025 With pause=0 throughout, N=(xe-cmd_x+1)*(ye-cmd_y+1) writes SHALL occur in cycles 1..N after acceptance, done in cycle N+1, and cmd_ready=1 in cycle N+2.
REQ-026 No address outside 0..WIDTH-1, 0..HEIGHT-1 SHALL ever be written.
REQ-027 In IDLE and DONE, write SHALL be 0.

Reset
REQ-028 When rst=1 on an edge, state SHALL become IDLE, and write=0, done=0, busy=0, x_data=0, y_data=0, color=0; cmd_ready SHALL be 1 after the first edge with rst=0.
REQ-029 Reset during DRAW SHALL abort the command with no further writes, and SHALL not produce a done pulse.
REQ-030 A command presented while rst=1 SHALL NOT be accepted.

Verification
REQ-031 A bench SHALL cover: cmd (x=2, y=3, w=3, h=2, color=0xA5), pause=0 -> writes (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) all colour 0xA5 in cycles 1-6, done in cycle 7, cmd_ready in cycle 8.
REQ-032 A bench SHALL cover: cmd (x=158, y=118, w=10, h=10) -> exactly 4 writes (158,118),(159,118),(158,119),(159,119), then done.
REQ-033 A bench SHALL cover: cmd (w=0) and cmd (x=200) -> zero writes, done in cycle 1, cmd_ready in cycle 2.
REQ-034 A bench SHALL cover: cmd 2x1 with pause=1 for cycles 1-3 -> write=0 with (x,y) held in cycles 1-3, writes in cycles 4-5, done in cycle 6.
REQ-035 A bench SHALL cover: rst=1 in cycle 3 of a 4x4 fill -> write=0 from the next edge onward, no done pulse, cmd_ready=1 after rst drops.
REQ-036 A bench SHALL cover: cmd_valid held high with changing inputs during DRAW -> no second acceptance until IDLE, and the latched colour is unchanged.
